// File: rtl/draw_rect_drop_ctl.sv
// draw_rect_drop_ctl: tracks the mouse, drops the rectangle on a left click, bounces it on a floor and lets it rest
module draw_rect_drop_ctl #(
   parameter int W          = 12,
   parameter int VW         = 8,
   parameter int FLOOR_Y    = 536,
   parameter int GRAVITY    = 1,
   parameter int V_MAX      = 63,
   parameter int DAMP_SHIFT = 2,
   parameter int V_MIN      = 2,
   parameter int CNT_W      = 4
) (
   input  logic             clk50hz,
   input  logic             rst_n,
   input  logic             left,
   input  logic             rearm,
   input  logic [W-1:0]     xpos,
   input  logic [W-1:0]     ypos,
   output logic [W-1:0]     xpos_ctl,
   output logic [W-1:0]     ypos_ctl,
   output logic             at_rest,
   output logic [CNT_W-1:0] bounce_cnt
);
   localparam logic signed [W:0]  FLOOR_S = (W+1)'(FLOOR_Y);
   localparam logic [W-1:0]       FLOOR_U = W'(FLOOR_Y);
   localparam logic signed [VW:0] VMAX_S  = (VW+1)'(V_MAX);
   localparam logic signed [VW:0] GRAV_S  = (VW+1)'(GRAVITY);
   localparam logic [VW-1:0]      VMIN_U  = VW'(V_MIN);

   if (V_MAX > 2**(VW-1)-1) begin : g_vmax_chk
      $fatal(1, "V_MAX does not fit in the signed velocity register");
   end
   if (FLOOR_Y >= 2**W) begin : g_floor_chk
      $fatal(1, "FLOOR_Y does not fit in the position bus");
   end

   typedef enum logic [1:0] {FOLLOW, FALL, REST} state_t;

   state_t               state;
   logic                 left_q;
   logic                 click;
   logic signed [VW-1:0] vel;
   logic signed [W:0]    y_next;
   logic signed [VW:0]   v_inc;
   logic [VW-1:0]        v_reb;

   // click edge, next airborne position, gravity step and damped rebound speed
   always_comb begin
      click  = left & ~left_q;
      y_next = $signed({1'b0, ypos_ctl}) + $signed({{(W+1-VW){vel[VW-1]}}, vel});
      v_inc  = $signed({vel[VW-1], vel}) + GRAV_S;
      v_reb  = $unsigned(vel) - ($unsigned(vel) >> DAMP_SHIFT);
   end

   // frame-rate state machine: rearm beats click beats motion, all outputs registered
   always_ff @(posedge clk50hz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FOLLOW;
         left_q     <= 1'b0;
         vel        <= '0;
         xpos_ctl   <= '0;
         ypos_ctl   <= '0;
         at_rest    <= 1'b0;
         bounce_cnt <= '0;
      end else begin
         left_q <= left;
         if (rearm || state == FOLLOW) begin
            state    <= FOLLOW;
            xpos_ctl <= xpos;
            ypos_ctl <= ypos;
            at_rest  <= 1'b0;
            if (rearm) begin
               vel <= '0;
            end else if (click) begin
               vel        <= '0;
               bounce_cnt <= '0;
               if (ypos >= FLOOR_U) begin
                  ypos_ctl <= FLOOR_U;
                  state    <= REST;
                  at_rest  <= 1'b1;
               end else begin
                  state <= FALL;
               end
            end
         end else if (state == FALL) begin
            if (y_next >= FLOOR_S) begin
               ypos_ctl <= FLOOR_U;
               if (v_reb < VMIN_U) begin
                  vel     <= '0;
                  state   <= REST;
                  at_rest <= 1'b1;
               end else begin
                  vel        <= -$signed(v_reb);
                  bounce_cnt <= bounce_cnt + {{(CNT_W-1){1'b0}}, ~&bounce_cnt};
               end
            end else if (y_next[W]) begin
               ypos_ctl <= '0;
               vel      <= '0;
            end else begin
               ypos_ctl <= y_next[W-1:0];
               vel      <= v_inc > VMAX_S ? VMAX_S[VW-1:0] : v_inc[VW-1:0];
            end
         end
      end
   end
endmodule

// File: tb/tb_draw_rect_drop_ctl.sv
// tb_draw_rect_drop_ctl: directed checks of drop, bounce, rest, rearm and reset over four parameter sets
module tb_draw_rect_drop_ctl;
   logic        clk50hz = 1'b0;
   logic        rst_n, left, rearm;
   logic [11:0] xpos, ypos;
   logic [11:0] xc[4], yc[4];
   logic        rs[4];
   logic [3:0]  bc[4];
   int          total = 0, bad = 0;
   int e0[24] = '{500,500,501,503,506,510,515,521,528,536,530,525,521,518,516,515,515,516,518,521,525,530,536,531};
   int e1[24] = '{500,500,501,503,506,510,515,521,528,536,532,529,527,526,526,527,529,532,536,534,533,533,534,536};
   int pat[6] = '{30,10,0,0,8,24};

   always #10 clk50hz = ~clk50hz;

   draw_rect_drop_ctl u0 (
      .clk50hz(clk50hz), .rst_n(rst_n), .left(left), .rearm(rearm), .xpos(xpos), .ypos(ypos),
      .xpos_ctl(xc[0]), .ypos_ctl(yc[0]), .at_rest(rs[0]), .bounce_cnt(bc[0]));
   draw_rect_drop_ctl #(.DAMP_SHIFT(1)) u1 (
      .clk50hz(clk50hz), .rst_n(rst_n), .left(left), .rearm(rearm), .xpos(xpos), .ypos(ypos),
      .xpos_ctl(xc[1]), .ypos_ctl(yc[1]), .at_rest(rs[1]), .bounce_cnt(bc[1]));
   draw_rect_drop_ctl #(.GRAVITY(8), .V_MAX(20), .DAMP_SHIFT(0)) u2 (
      .clk50hz(clk50hz), .rst_n(rst_n), .left(left), .rearm(rearm), .xpos(xpos), .ypos(ypos),
      .xpos_ctl(xc[2]), .ypos_ctl(yc[2]), .at_rest(rs[2]), .bounce_cnt(bc[2]));
   draw_rect_drop_ctl #(.GRAVITY(8), .V_MAX(20), .DAMP_SHIFT(7), .FLOOR_Y(30)) u3 (
      .clk50hz(clk50hz), .rst_n(rst_n), .left(left), .rearm(rearm), .xpos(xpos), .ypos(ypos),
      .xpos_ctl(xc[3]), .ypos_ctl(yc[3]), .at_rest(rs[3]), .bounce_cnt(bc[3]));

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk50hz);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; left = 1'b0; rearm = 1'b0; xpos = 12'd100; ypos = 12'd500;
      #25;
      chk("rst x", xc[0], 0);
      chk("rst y", yc[0], 0);
      chk("rst rest", rs[0], 0);
      chk("rst cnt", bc[0], 0);
      rst_n = 1'b1;
      tick();
      chk("follow y", yc[0], 500);
      chk("follow x", xc[0], 100);
      left = 1'b1;
      tick();
      left = 1'b0;
      for (int n = 1; n <= 24; n++) begin
         if (n > 1) tick();
         chk($sformatf("u0 y s%0d", n), yc[0], e0[n-1]);
         chk($sformatf("u0 x s%0d", n), xc[0], 100);
         chk($sformatf("u0 cnt s%0d", n), bc[0], n >= 23 ? 2 : n >= 10 ? 1 : 0);
         chk($sformatf("u1 y s%0d", n), yc[1], e1[n-1]);
         chk($sformatf("u1 cnt s%0d", n), bc[1], n >= 19 ? 2 : n >= 10 ? 1 : 0);
         chk($sformatf("u1 rest s%0d", n), rs[1], n >= 24 ? 1 : 0);
      end
      repeat (150) tick();
      chk("u0 cnt sat", bc[0], 15);
      chk("u0 no rest", rs[0], 0);
      chk("u1 rest y", yc[1], 536);
      chk("u1 rest cnt", bc[1], 2);
      left = 1'b1;
      tick();
      left = 1'b0;
      tick();
      chk("u1 rest click", rs[1], 1);
      chk("u1 rest click y", yc[1], 536);
      chk("u1 rest click cnt", bc[1], 2);
      chk("u1 rest click x", xc[1], 100);
      rearm = 1'b1;
      tick();
      rearm = 1'b0; xpos = 12'd30; ypos = 12'd200;
      tick();
      chk("rearm y0", yc[0], 200);
      chk("rearm x0", xc[0], 30);
      chk("rearm rest1", rs[1], 0);
      chk("rearm y1", yc[1], 200);
      ypos = 12'd600; left = 1'b1;
      tick();
      left = 1'b0;
      chk("deep y0", yc[0], 536);
      chk("deep rest0", rs[0], 1);
      chk("deep cnt0", bc[0], 0);
      chk("deep cnt1", bc[1], 0);
      rearm = 1'b1;
      tick();
      left = 1'b1;
      tick();
      chk("rearm blocks click y", yc[0], 600);
      chk("rearm blocks click rest", rs[0], 0);
      rearm = 1'b0;
      tick();
      chk("held left y", yc[0], 600);
      chk("held left rest", rs[0], 0);
      rst_n = 1'b0; left = 1'b1; xpos = 12'd10; ypos = 12'd530;
      #5;
      rst_n = 1'b1;
      tick();
      chk("held drop y", yc[1], 530);
      repeat (9) tick();
      chk("held rest y", yc[1], 536);
      chk("held rest", rs[1], 1);
      chk("held cnt", bc[1], 1);
      repeat (3) tick();
      chk("held still rest", rs[1], 1);
      rearm = 1'b1;
      tick();
      rearm = 1'b0; ypos = 12'd400;
      tick();
      chk("held rearm y", yc[1], 400);
      chk("held rearm rest", rs[1], 0);
      ypos = 12'd410;
      tick();
      chk("held no drop y", yc[1], 410);
      chk("held no drop cnt", bc[1], 1);
      left = 1'b0;
      tick();
      left = 1'b1;
      tick();
      chk("repress y", yc[1], 410);
      chk("repress cnt", bc[1], 0);
      ypos = 12'd420;
      tick();
      chk("repress fall1", yc[1], 410);
      tick();
      chk("repress fall2", yc[1], 411);
      rst_n = 1'b0; left = 1'b0; xpos = 12'd5; ypos = 12'd0;
      #5;
      rst_n = 1'b1;
      tick();
      chk("g8 follow x", xc[3], 5);
      left = 1'b1;
      tick();
      left = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         if (n > 1) tick();
         chk($sformatf("u2 y s%0d", n), yc[2], n <= 2 ? 0 : n == 3 ? 8 : n == 4 ? 24 : n < 30 ? 44 + 20 * (n - 5) : 536);
         chk($sformatf("u2 rest s%0d", n), rs[2], n >= 30 ? 1 : 0);
         chk($sformatf("u3 y s%0d", n), yc[3], n <= 2 ? 0 : n == 3 ? 8 : n == 4 ? 24 : pat[(n-5)%6]);
         chk($sformatf("u3 cnt s%0d", n), bc[3], n < 5 ? 0 : (1 + (n - 5) / 6 > 15 ? 15 : 1 + (n - 5) / 6));
      end
      chk("u2 cnt", bc[2], 0);
      chk("u3 no rest", rs[3], 0);
      #4;
      rst_n = 1'b0;
      #1;
      chk("async x3", xc[3], 0);
      chk("async y3", yc[3], 0);
      chk("async cnt3", bc[3], 0);
      chk("async y2", yc[2], 0);
      chk("async rest2", rs[2], 0);
      #2;
      xpos = 12'd9; ypos = 12'd77;
      rst_n = 1'b1;
      tick();
      chk("post rst y3", yc[3], 77);
      chk("post rst x3", xc[3], 9);
      chk("post rst y2", yc[2], 77);
      tick();
      chk("post rst hold y3", yc[3], 77);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
